// File: rtl/i2c_slave_top.sv
// -----------------------------------------------------------------------------
// i2c_slave_top
//
// I2C slave exposing NUM_REGS 8-bit registers behind an 8-bit register
// pointer. A write transaction loads the pointer from its first data byte and
// writes every following byte to regs[pointer], auto-incrementing. A read
// transaction returns regs[pointer] and auto-increments while the master ACKs.
// Pointer values at or above NUM_REGS are ACKed on write with the data
// discarded, and read back as 8'h00. No clock stretching is used.
//
// Parameters
//   SLAVE_ADDR : 7-bit device address (default 7'h24)
//   NUM_REGS   : number of implemented registers, power of two, 2..256
//
// Ports
//   clk      : system clock (10 MHz or faster), rising edge
//   button_0 : asynchronous active-high reset
//   scl      : I2C clock from the master
//   sda      : open-drain I2C data; driven only to 1'b0 or released (1'bz)
//
// Build option
//   I2C_GLITCH_FILTER_EN : when defined, a synchronized scl/sda level must
//                          be stable for 3 clk cycles before it is accepted.
// -----------------------------------------------------------------------------
module i2c_slave_top #(
  parameter logic [6:0] SLAVE_ADDR = 7'h24,
  parameter int         NUM_REGS   = 16
) (
  input  logic clk,
  input  logic button_0,
  input  logic scl,
  inout  wire  sda
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [3:0] {
    IDLE,
    DEV_ADDR,
    DEV_ACK,
    REG_ADDR,
    REG_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizers; idle bus level is high, so they reset to 1.
  // ---------------------------------------------------------------------------
  logic scl_meta, scl_sync, sda_meta, sda_sync;

  always_ff @(posedge clk or posedge button_0) begin
    if (button_0) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each flop sample the previous
      // stage's old value, which is what builds a real two-stage chain.
      scl_meta <= scl;
      scl_sync <= scl_meta;
      sda_meta <= sda;
      sda_sync <= sda_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional glitch filter: a new level is accepted on its 3rd stable cycle.
  // ---------------------------------------------------------------------------
  logic scl_f, sda_f;

`ifdef I2C_GLITCH_FILTER_EN
  logic [1:0] scl_cnt, sda_cnt;

  always_ff @(posedge clk or posedge button_0) begin
    if (button_0) begin
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_cnt <= 2'd0;
      sda_cnt <= 2'd0;
    end else begin
      if (scl_sync == scl_f) begin
        scl_cnt <= 2'd0;
      end else if (scl_cnt == 2'd2) begin
        scl_f   <= scl_sync;
        scl_cnt <= 2'd0;
      end else begin
        scl_cnt <= scl_cnt + 2'd1;
      end

      if (sda_sync == sda_f) begin
        sda_cnt <= 2'd0;
      end else if (sda_cnt == 2'd2) begin
        sda_f   <= sda_sync;
        sda_cnt <= 2'd0;
      end else begin
        sda_cnt <= sda_cnt + 2'd1;
      end
    end
  end
`else
  assign scl_f = scl_sync;
  assign sda_f = sda_sync;
`endif

  // ---------------------------------------------------------------------------
  // Edge and bus-condition detection against a one-cycle-delayed copy.
  // ---------------------------------------------------------------------------
  logic scl_d, sda_d;

  always_ff @(posedge clk or posedge button_0) begin
    if (button_0) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_rise  = scl_f & ~scl_d;
  assign scl_fall  = ~scl_f & scl_d;
  assign start_det = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_det  = scl_f & scl_d & ~sda_d & sda_f;

  // ---------------------------------------------------------------------------
  // Register file access helpers.
  // ---------------------------------------------------------------------------
  state_t     state;
  logic       sda_oe;      // 1 = pull sda low
  logic       rw;          // R/W bit of the current address byte
  logic [3:0] bit_cnt;     // bits received, or bits presented during a read
  logic [6:0] rx_sh;       // first seven bits of the byte being received
  logic [7:0] ptr;
  logic [7:0] regs [NUM_REGS];

  logic [7:0] rx_byte;
  logic       ptr_in_range;
  logic [7:0] rd_byte;
  logic [2:0] tx_idx;

  assign rx_byte      = {rx_sh, sda_f};
  assign ptr_in_range = ({1'b0, ptr} < 9'(NUM_REGS));
  assign rd_byte      = ptr_in_range ? regs[ptr[AW-1:0]] : 8'h00;
  assign tx_idx       = 3'(4'd7 - bit_cnt);

  // ---------------------------------------------------------------------------
  // Protocol FSM. ACK states use sda_oe as their phase: the first scl fall
  // starts the ACK drive, the second one ends it and advances the state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge button_0) begin
    if (button_0) begin
      state   <= IDLE;
      sda_oe  <= 1'b0;
      rw      <= 1'b0;
      bit_cnt <= 4'd0;
      rx_sh   <= 7'd0;
      ptr     <= 8'h00;
      // NOTE: the register file is cleared by reset because its contents are
      // visible over the bus right after reset; do not drop this loop.
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
    end else if (start_det) begin
      state   <= DEV_ADDR;
      sda_oe  <= 1'b0;
      bit_cnt <= 4'd0;
    end else if (stop_det) begin
      state   <= IDLE;
      sda_oe  <= 1'b0;
      bit_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: ;

        DEV_ADDR: if (scl_rise) begin
          rx_sh <= rx_byte[6:0];
          if (bit_cnt == 4'd7) begin
            bit_cnt <= 4'd0;
            if (rx_byte[7:1] == SLAVE_ADDR) begin
              rw    <= rx_byte[0];
              state <= DEV_ACK;
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end

        DEV_ACK: if (scl_fall) begin
          if (!sda_oe) begin
            sda_oe <= 1'b1;
          end else if (rw) begin
            // ACK ends on the same fall that presents the first data bit.
            state   <= RD_DATA;
            bit_cnt <= 4'd0;
            sda_oe  <= ~rd_byte[7];
          end else begin
            state  <= REG_ADDR;
            sda_oe <= 1'b0;
          end
        end

        REG_ADDR: if (scl_rise) begin
          rx_sh <= rx_byte[6:0];
          if (bit_cnt == 4'd7) begin
            bit_cnt <= 4'd0;
            ptr     <= rx_byte;
            state   <= REG_ACK;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end

        REG_ACK: if (scl_fall) begin
          if (!sda_oe) begin
            sda_oe <= 1'b1;
          end else begin
            sda_oe <= 1'b0;
            state  <= WR_DATA;
          end
        end

        WR_DATA: if (scl_rise) begin
          rx_sh <= rx_byte[6:0];
          if (bit_cnt == 4'd7) begin
            bit_cnt <= 4'd0;
            if (ptr_in_range) regs[ptr[AW-1:0]] <= rx_byte;
            state <= WR_ACK;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
          end
        end

        WR_ACK: if (scl_fall) begin
          if (!sda_oe) begin
            sda_oe <= 1'b1;
          end else begin
            sda_oe <= 1'b0;
            ptr    <= ptr + 8'd1;
            state  <= WR_DATA;
          end
        end

        // bit_cnt counts scl rises of the byte; each fall presents the next
        // bit, and the fall after the 8th rise releases sda for the master.
        RD_DATA: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            bit_cnt <= bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe <= 1'b0;
              state  <= RD_ACK;
            end else begin
              sda_oe <= ~rd_byte[tx_idx];
            end
          end
        end

        RD_ACK: if (scl_rise) begin
          if (!sda_f) begin
            ptr     <= ptr + 8'd1;
            bit_cnt <= 4'd0;
            state   <= RD_DATA;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state  <= IDLE;
          sda_oe <= 1'b0;
        end
      endcase
    end
  end

  assign sda = sda_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave_top.sv
// -----------------------------------------------------------------------------
// tb_i2c_slave_top
//
// Bit-banged I2C master at 400 kHz driving i2c_slave_top. Each byte task
// pushes the expected slave response (ACK bit or read data) into a queue;
// a monitor process pops and compares each time the master captures a
// slave-driven slot.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_slave_top;

  localparam time Q = 625;  // quarter of a 2.5 us (400 kHz) scl period

  logic clk      = 1'b0;
  logic button_0 = 1'b1;
  logic scl      = 1'b1;
  logic m_oe     = 1'b0;    // master pulls sda low
  wire  sda;

  assign sda = m_oe ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave_top #(
    .SLAVE_ADDR (7'h24),
    .NUM_REGS   (16)
  ) dut (
    .clk      (clk),
    .button_0 (button_0),
    .scl      (scl),
    .sda      (sda)
  );

  // 10 MHz; offset so clock edges never coincide with master bus activity.
  initial begin
    #10;
    forever #50 clk = ~clk;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    string      name;
    logic [7:0] value;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] obs_value;
  event       obs_ev;
  int         total  = 0;
  int         passed = 0;
  int         slave_low = 0;  // clk cycles where sda was low and master released

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, required %h", nm, act, exp);
    else passed++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(obs_ev);
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_output: got %h, required no output", obs_value);
      end else begin
        e = exp_q.pop_front();
        check(e.name, obs_value, e.value);
      end
    end
  end

  always @(posedge clk) begin
    if (!m_oe && sda === 1'b0) slave_low <= slave_low + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got time limit, required end of stimulus");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Bus-level master tasks
  // ---------------------------------------------------------------------------
  task automatic put_bit(input logic b);
    m_oe = ~b;
    #Q scl = 1'b1;
    #(2*Q) scl = 1'b0;
    #Q;
  endtask

  task automatic get_bit(output logic b);
    m_oe = 1'b0;
    #Q scl = 1'b1;
    #Q b = sda;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_start();
    m_oe = 1'b0;
    #Q scl = 1'b1;
    #Q m_oe = 1'b1;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop();
    m_oe = 1'b1;
    #Q scl = 1'b1;
    #Q m_oe = 1'b0;
    #(4*Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string nm);
    logic a;
    exp_q.push_back('{name: nm, value: {7'd0, exp_ack}});
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(a);
    obs_value = {7'd0, a};
    -> obs_ev;
  endtask

  task automatic recv_byte(input logic [7:0] exp, input logic m_ack, input string nm);
    logic [7:0] d;
    exp_q.push_back('{name: nm, value: exp});
    for (int i = 7; i >= 0; i--) get_bit(d[i]);
    obs_value = d;
    -> obs_ev;
    put_bit(~m_ack);
  endtask

  task automatic write_one(input logic [7:0] r, input logic [7:0] d);
    i2c_start();
    send_byte(8'h48, 1'b0, "wr_addr_ack");
    send_byte(r,     1'b0, "wr_reg_ack");
    send_byte(d,     1'b0, "wr_data_ack");
    i2c_stop();
  endtask

  task automatic read_one(input logic [7:0] r, input logic [7:0] exp, input string nm);
    i2c_start();
    send_byte(8'h48, 1'b0, "rd_waddr_ack");
    send_byte(r,     1'b0, "rd_reg_ack");
    i2c_start();
    send_byte(8'h49, 1'b0, "rd_raddr_ack");
    recv_byte(exp, 1'b0, nm);
    i2c_stop();
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  int low_mark;

  initial begin
    #1000;
    check("reset_sda_released_during_reset", {7'd0, sda}, 8'h01);
    button_0 = 1'b0;
    #1000;
    check("reset_sda_released_after_reset", {7'd0, sda}, 8'h01);

    // Out-of-range register read returns zero with every ACK given.
    read_one(8'h8F, 8'h00, "rd_out_of_range_8f");

    // Writes, then read back through a repeated START.
    write_one(8'h03, 8'h7B);
    write_one(8'h01, 8'h7A);
    write_one(8'h00, 8'hCB);
    read_one(8'h03, 8'h7B, "rd_reg03_after_writes");

    // Wrong address: nothing is ACKed and sda is never pulled low.
    low_mark = slave_low;
    i2c_start();
    send_byte(8'h30, 1'b1, "bad_wr_addr_nack");
    send_byte(8'h82, 1'b1, "bad_wr_reg_nack");
    send_byte(8'h7A, 1'b1, "bad_wr_data_nack");
    i2c_stop();
    check("bad_wr_no_slave_drive", 8'(slave_low - low_mark), 8'h00);

    // Pointer (still 0x03) and register contents survive the ignored write.
    i2c_start();
    send_byte(8'h49, 1'b0, "cur_rd_addr_ack");
    recv_byte(8'h7B, 1'b0, "cur_rd_reg03_unchanged");
    i2c_stop();

    // Wrong read address: NACK and the bus is free after STOP.
    low_mark = slave_low;
    i2c_start();
    send_byte(8'h47, 1'b1, "bad_rd_addr_nack");
    i2c_stop();
    check("bad_rd_sda_released", {7'd0, sda}, 8'h01);
    check("bad_rd_no_slave_drive", 8'(slave_low - low_mark), 8'h00);

    // Burst across the top of the register file.
    i2c_start();
    send_byte(8'h48, 1'b0, "bw_addr_ack");
    send_byte(8'h0F, 1'b0, "bw_reg_ack");
    send_byte(8'h11, 1'b0, "bw_data0_ack");
    send_byte(8'h22, 1'b0, "bw_data1_discard_ack");
    i2c_stop();
    i2c_start();
    send_byte(8'h48, 1'b0, "br_waddr_ack");
    send_byte(8'h0F, 1'b0, "br_reg_ack");
    i2c_start();
    send_byte(8'h49, 1'b0, "br_raddr_ack");
    recv_byte(8'h11, 1'b1, "br_reg0f");
    recv_byte(8'h00, 1'b0, "br_ptr10_zero");
    i2c_stop();
    check("br_sda_released", {7'd0, sda}, 8'h01);

    // Reset in the middle of a data byte.
    i2c_start();
    send_byte(8'h48, 1'b0, "rst_addr_ack");
    send_byte(8'h05, 1'b0, "rst_reg_ack");
    put_bit(1'b1);
    put_bit(1'b0);
    put_bit(1'b1);
    put_bit(1'b0);
    m_oe = 1'b0;
    button_0 = 1'b1;
    #500;
    check("rst_mid_byte_sda_released", {7'd0, sda}, 8'h01);
    #500;
    button_0 = 1'b0;
    #500;
    i2c_stop();

    // All registers cleared: burst regs 0..3, then reg 0x0F.
    i2c_start();
    send_byte(8'h48, 1'b0, "post_rst_waddr_ack");
    send_byte(8'h00, 1'b0, "post_rst_reg_ack");
    i2c_start();
    send_byte(8'h49, 1'b0, "post_rst_raddr_ack");
    recv_byte(8'h00, 1'b1, "post_rst_reg00");
    recv_byte(8'h00, 1'b1, "post_rst_reg01");
    recv_byte(8'h00, 1'b1, "post_rst_reg02");
    recv_byte(8'h00, 1'b0, "post_rst_reg03");
    i2c_stop();
    read_one(8'h0F, 8'h00, "post_rst_reg0f");

    // A normal transaction works after the reset.
    write_one(8'h07, 8'h5A);
    read_one(8'h07, 8'h5A, "post_rst_rd_reg07");

    #(8*Q);
    check("scoreboard_drained", 8'(exp_q.size()), 8'h00);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/i2c_slave_top.md
I2C_SLAVE_TOP -- requirements
Module: i2c_slave_top

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h24, the 7-bit I2C device address.
REQ-002 SHALL have parameter NUM_REGS, default 16, the number of implemented 8-bit registers (power of two, at most 256).
REQ-003 SHALL have port clk, input, 1 bit: system clock, nominally 10 MHz; every flop is clocked on its rising edge.
REQ-004 SHALL have port button_0, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port scl, input, 1 bit: I2C clock from the master, externally pulled up.
REQ-006 SHALL have port sda, inout, 1 bit: open-drain I2C data; the block drives only 1'b0 or 1'bz, never 1'b1.

Function
REQ-007 SHALL pass scl and sda through a 2-flop synchronizer before any use; edge detection compares the synchronized value with its one-cycle-delayed copy.
REQ-008 SHALL detect START as a synchronized sda falling edge while synchronized scl is high, and STOP as a synchronized sda rising edge while synchronized scl is high.
REQ-009 SHALL support standard and fast mode (SCL up to 400 kHz) at clk of 10 MHz or faster, with no clock stretching.
REQ-010 SHALL use the states IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA and RD_ACK.
REQ-011 SHALL move from any state to DEV_ADDR on START, including a repeated START, and clear the bit counter.
REQ-012 SHALL move from any state to IDLE on STOP and release sda.
REQ-013 SHALL sample received bits, MSB first, on the synchronized scl rising edge; the 8th bit completes a byte.
REQ-014 SHALL, in DEV_ADDR, compare bits [7:1] with SLAVE_ADDR; on mismatch it goes to IDLE and never drives sda until the next START.
REQ-015 SHALL, on address match, drive sda low for the ACK bit; the drive begins on the scl falling edge after bit 8 and releases on the following scl falling edge.
REQ-016 SHALL, when R/W = 0, go to REG_ADDR; the received byte loads the register pointer, is ACKed, and the state then goes to WR_DATA.
REQ-017 SHALL, in WR_DATA, write each received byte to regs[pointer], ACK it, and then increment the pointer modulo 256.
REQ-018 SHALL, when R/W = 1, go to RD_DATA and shift out regs[pointer], MSB first, with sda updated on each scl falling edge; driving a 1 means releasing sda.
REQ-019 SHALL, in RD_ACK, sample the master bit at scl rise: ACK (0) increments the pointer and sends the next byte; NACK (1) goes to IDLE and releases sda.
REQ-020 SHALL, when the pointer is at or above NUM_REGS, ACK writes and discard the data, and return 8'h00 on reads.
REQ-021 SHALL keep the pointer across transactions, so a write of the pointer, a repeated START and then a read return regs[pointer].
REQ-022 SHALL let STOP or START in the middle of a byte abort that byte with no register update.

Reset
REQ-023 SHALL, while button_0 = 1, asynchronously force state = IDLE, sda released, pointer = 8'h00, all registers = 8'h00 and both synchronizers = 1.
REQ-024 SHALL treat button_0 asserted in the middle of a transaction as an abort; the block resumes at the next START after reset is released.

Configuration
REQ-025 SHALL, when I2C_GLITCH_FILTER_EN is defined, require each synchronized scl and sda to hold a new level for 3 consecutive clk cycles before that level is accepted, which suppresses spikes shorter than 3 clk periods.
REQ-026 SHALL, when I2C_GLITCH_FILTER_EN is undefined, use the synchronizer outputs directly; this has 3 fewer cycles of latency, and the protocol behaviour is otherwise identical.

Verification
REQ-027 SHALL be checked with the scenario: reset, then read from address 0x24 at register 0x8F at 400 kHz -> all ACKs returned, data read = 8'h00.
REQ-028 SHALL be checked with the scenario: write 0x7B to reg 0x03, 0x7A to reg 0x01 and 0xCB to reg 0x00, then read reg 0x03 using a repeated START -> 8'h7B.
REQ-029 SHALL be checked with the scenario: write with 7-bit address 0x18 (7'h98 truncated), reg 0x82, data 0x7A -> address NACKed, sda never driven low, registers unchanged.
REQ-030 SHALL be checked with the scenario: read with 7-bit address 0x23 (7'hA3 truncated) -> NACK, and the bus is released at STOP.
REQ-031 SHALL be checked with the scenario: burst write 0x11, 0x22 to reg 0x0F, then burst read from 0x0F -> reads 0x11, then 0x00 at pointer 0x10, then NACK ends the transfer.
REQ-032 SHALL be checked with the scenario: assert button_0 during the data byte of a write -> sda released and all registers 8'h00 after reset, and the next transaction succeeds.
